// File: rtl/mem_arbiter.sv
// Byte-serial owner of the shared RAM/IO port: round-robin between instruction fetch
// and the load/store buffer, little-endian assembly of reads and splitting of writes.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h00030000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  mispredict,
  input  logic                  if_en,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ok,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  lsb_en,
  input  logic                  lsb_wr,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [DATA_WIDTH-1:0] lsb_wdata,
  input  logic [2:0]            lsb_width,
  output logic                  lsb_ok,
  output logic [DATA_WIDTH-1:0] lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LSB} owner_t;

  state_t                r_state;
  owner_t                r_owner;
  owner_t                r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_width;
  logic [2:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_asm;
  logic [ADDR_WIDTH-1:0] r_mem_a;
  logic [7:0]            r_mem_dout;
  logic                  r_mem_wr;
  logic                  r_if_ok;
  logic [DATA_WIDTH-1:0] r_if_data;
  logic                  r_lsb_ok;
  logic [DATA_WIDTH-1:0] r_lsb_rdata;

  logic                  w_grant_if;
  logic                  w_grant_lsb;
  logic [2:0]            w_lsb_width;
  logic                  w_acc_stall;
  logic                  w_io_stall;
  logic [2:0]            w_cnt_inc;
  logic [7:0]            w_wbyte;
  logic [DATA_WIDTH-1:0] w_asm;

  // A flush suppresses any grant in the same cycle.
  always_comb begin
    w_grant_if  = 1'b0;
    w_grant_lsb = 1'b0;
    if (!mispredict) begin
      if (if_en && lsb_en) begin
        if (r_last_grant == OWN_IF) w_grant_lsb = 1'b1;
        else                        w_grant_if  = 1'b1;
      end else begin
        w_grant_if  = if_en;
        w_grant_lsb = lsb_en;
      end
    end
  end

  assign w_lsb_width = (lsb_width == 3'd1) ? 3'd1 : (lsb_width == 3'd2) ? 3'd2 : 3'd4;
  assign w_acc_stall = (lsb_addr >= IO_BASE) && io_buffer_full;
  assign w_io_stall  = (r_addr >= IO_BASE) && io_buffer_full;
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_wbyte     = 8'(r_wdata >> {r_cnt, 3'b000});
  assign w_asm       = r_asm | (DATA_WIDTH'(mem_din) << {r_cnt, 3'b000});

  // r_cnt counts bytes already captured (read) or already issued (write).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_last_grant <= OWN_IF;
      r_addr       <= '0;
      r_width      <= 3'd4;
      r_cnt        <= '0;
      r_wdata      <= '0;
      r_asm        <= '0;
      r_mem_a      <= '0;
      r_mem_dout   <= '0;
      r_mem_wr     <= 1'b0;
      r_if_ok      <= 1'b0;
      r_if_data    <= '0;
      r_lsb_ok     <= 1'b0;
      r_lsb_rdata  <= '0;
    end else if (rdy) begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_if || w_grant_lsb) begin
            r_owner      <= w_grant_lsb ? OWN_LSB : OWN_IF;
            r_last_grant <= w_grant_lsb ? OWN_LSB : OWN_IF;
            r_addr       <= w_grant_lsb ? lsb_addr : if_addr;
            r_mem_a      <= w_grant_lsb ? lsb_addr : if_addr;
            r_width      <= w_grant_lsb ? w_lsb_width : 3'd4;
            r_wdata      <= lsb_wdata;
            r_asm        <= '0;
            r_cnt        <= '0;
            if (w_grant_lsb && lsb_wr) begin
              r_state <= S_WRITE;
              if (w_acc_stall) begin
                r_mem_wr <= 1'b0;
              end else begin
                r_mem_dout <= lsb_wdata[7:0];
                r_mem_wr   <= 1'b1;
                r_cnt      <= 3'd1;
              end
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_READ: begin
          if (mispredict) begin
            r_state <= S_IDLE;
          end else begin
            r_asm   <= w_asm;
            r_cnt   <= w_cnt_inc;
            r_mem_a <= r_addr + ADDR_WIDTH'(w_cnt_inc);
            if (w_cnt_inc == r_width) begin
              r_state <= S_DONE;
              if (r_owner == OWN_IF) begin
                r_if_ok   <= 1'b1;
                r_if_data <= w_asm;
              end else begin
                r_lsb_ok    <= 1'b1;
                r_lsb_rdata <= w_asm;
              end
            end
          end
        end
        S_WRITE: begin
          if (r_cnt == r_width) begin
            r_mem_wr <= 1'b0;
            r_lsb_ok <= 1'b1;
            r_state  <= S_DONE;
          end else if (w_io_stall) begin
            r_mem_wr <= 1'b0;
          end else begin
            r_mem_a    <= r_addr + ADDR_WIDTH'(r_cnt);
            r_mem_dout <= w_wbyte;
            r_mem_wr   <= 1'b1;
            r_cnt      <= w_cnt_inc;
          end
        end
        S_DONE: begin
          r_if_ok  <= 1'b0;
          r_lsb_ok <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ok     = r_if_ok;
  assign if_data   = r_if_data;
  assign lsb_ok    = r_lsb_ok;
  assign lsb_rdata = r_lsb_rdata;
  assign mem_dout  = r_mem_dout;
  assign mem_a     = r_mem_a;
  assign mem_wr    = r_mem_wr & rdy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: byte RAM model with combinational read, scoreboard of expected ok pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, mispredict;
  logic        if_en;
  logic [31:0] if_addr;
  logic        if_ok;
  logic [31:0] if_data;
  logic        lsb_en, lsb_wr;
  logic [31:0] lsb_addr, lsb_wdata;
  logic [2:0]  lsb_width;
  logic        lsb_ok;
  logic [31:0] lsb_rdata;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IO_BASE(32'h00030000)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .mispredict(mispredict),
    .if_en(if_en), .if_addr(if_addr), .if_ok(if_ok), .if_data(if_data),
    .lsb_en(lsb_en), .lsb_wr(lsb_wr), .lsb_addr(lsb_addr), .lsb_wdata(lsb_wdata),
    .lsb_width(lsb_width), .lsb_ok(lsb_ok), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  // RAM: unwritten bytes follow dflt(); 0x100..0x103 = 11 22 33 44, 0x300..0x303 = 13 24 35 46.
  logic [7:0] ram_w [0:4095];
  logic       ram_v [0:4095];
  typedef struct { logic [31:0] a; logic [7:0] d; } wr_t;
  wr_t wlog[$];
  int  wr_cycles = 0;

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return 8'(({6'd0, a[1:0]} + 8'd1) * 8'h11 + {4'd0, a[11:8]} - 8'd1);
  endfunction

  assign mem_din = ram_v[mem_a[11:0]] ? ram_w[mem_a[11:0]] : dflt(mem_a);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4096; i++) ram_v[i] <= 1'b0;
    end else if (mem_wr) begin
      wlog.push_back('{mem_a, mem_dout});
      wr_cycles <= wr_cycles + 1;
      if (mem_a < 32'h00030000) begin
        ram_w[mem_a[11:0]] <= mem_dout;
        ram_v[mem_a[11:0]] <= 1'b1;
      end
    end
  end

  typedef struct { bit owner; bit wr; logic [31:0] data; int cyc; } exp_t;
  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit owner, input bit wr, input logic [31:0] data, input int c);
    sb.push_back('{owner, wr, data, c});
  endtask

  task automatic take_ok(input bit owner, input logic ok, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      chk(owner ? "spurious_lsb_ok" : "spurious_if_ok", {31'd0, ok}, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("ok_owner", {31'd0, owner}, {31'd0, e.owner});
    if (!e.wr) chk("ok_data", data, e.data);
    chk("ok_cycle", 32'(cyc), 32'(e.cyc));
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (if_ok)  take_ok(1'b0, if_ok, if_data);
    if (lsb_ok) take_ok(1'b1, lsb_ok, lsb_rdata);
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      step();
      n++;
    end
    chk("ok_timeout_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] a, input logic [7:0] d);
    if (idx < wlog.size()) begin
      chk({tag, "_addr"}, wlog[idx].a, a);
      chk({tag, "_data"}, {24'd0, wlog[idx].d}, {24'd0, d});
    end else begin
      chk({tag, "_missing"}, 32'(wlog.size()), 32'(idx + 1));
    end
  endtask

  task automatic lsb_req(input bit wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] w);
    lsb_en = 1'b1; lsb_wr = wr; lsb_addr = a; lsb_wdata = wd; lsb_width = w;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, l0, w0;
    rst = 1'b1; rdy = 1'b1; mispredict = 1'b0; io_buffer_full = 1'b0;
    if_en = 1'b0; if_addr = '0;
    lsb_en = 1'b0; lsb_wr = 1'b0; lsb_addr = '0; lsb_wdata = '0; lsb_width = 3'd4;
    idle(2);
    chk("rst_if_ok", {31'd0, if_ok}, 32'd0);
    chk("rst_lsb_ok", {31'd0, lsb_ok}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst = 1'b0;
    idle(1);

    // Both requesting from reset: LSB, IF, LSB, six cycles apart.
    n = cyc;
    if_en = 1'b1; if_addr = 32'h100;
    lsb_req(1'b0, 32'h300, 32'h0, 3'd4);
    push(1'b1, 1'b0, 32'h46352413, n + 5);
    push(1'b0, 1'b0, 32'h44332211, n + 11);
    push(1'b1, 1'b0, 32'h46352413, n + 17);
    drain(30);
    if_en = 1'b0; lsb_en = 1'b0;
    idle(3);

    // IF word fetch alone.
    n = cyc;
    if_en = 1'b1; if_addr = 32'h100;
    push(1'b0, 1'b0, 32'h44332211, n + 5);
    drain(20);
    if_en = 1'b0;
    idle(2);

    // SH then LH readback (zero-extended).
    n = cyc; l0 = wlog.size(); w0 = wr_cycles;
    lsb_req(1'b1, 32'h200, 32'hAABBCCDD, 3'd2);
    push(1'b1, 1'b1, 32'h0, n + 3);
    drain(20);
    lsb_en = 1'b0;
    idle(2);
    chk("sh_wr_cycles", 32'(wr_cycles - w0), 32'd2);
    chk_wr("sh_b0", l0, 32'h200, 8'hDD);
    chk_wr("sh_b1", l0 + 1, 32'h201, 8'hCC);
    n = cyc;
    lsb_req(1'b0, 32'h200, 32'h0, 3'd2);
    push(1'b1, 1'b0, 32'h0000CCDD, n + 3);
    drain(20);
    lsb_en = 1'b0;
    idle(2);

    // LB: single-byte latency.
    n = cyc;
    lsb_req(1'b0, 32'h301, 32'h0, 3'd1);
    push(1'b1, 1'b0, 32'h00000024, n + 2);
    drain(20);
    lsb_en = 1'b0;
    idle(2);

    // Mispredict in IDLE delays the grant by one edge.
    n = cyc;
    if_en = 1'b1; if_addr = 32'h100; mispredict = 1'b1;
    step();
    mispredict = 1'b0;
    push(1'b0, 1'b0, 32'h44332211, n + 6);
    drain(20);
    if_en = 1'b0;
    idle(2);

    // LW aborted at E2; an IF presented next cycle is accepted on the following edge.
    n = cyc;
    lsb_req(1'b0, 32'h300, 32'h0, 3'd4);
    step(); step();
    mispredict = 1'b1; lsb_en = 1'b0;
    step();
    mispredict = 1'b0;
    if_en = 1'b1; if_addr = 32'h100;
    push(1'b0, 1'b0, 32'h44332211, n + 8);
    drain(20);
    if_en = 1'b0;
    idle(3);

    // SW with mispredict mid-write still completes.
    n = cyc; l0 = wlog.size(); w0 = wr_cycles;
    lsb_req(1'b1, 32'h204, 32'h01020304, 3'd4);
    push(1'b1, 1'b1, 32'h0, n + 5);
    step(); step();
    mispredict = 1'b1;
    step();
    mispredict = 1'b0;
    drain(20);
    lsb_en = 1'b0;
    idle(2);
    chk("sw_wr_cycles", 32'(wr_cycles - w0), 32'd4);
    chk_wr("sw_b0", l0, 32'h204, 8'h04);
    chk_wr("sw_b1", l0 + 1, 32'h205, 8'h03);
    chk_wr("sw_b2", l0 + 2, 32'h206, 8'h02);
    chk_wr("sw_b3", l0 + 3, 32'h207, 8'h01);

    // Width 7 behaves as a word; address wraps past 0xFFFFFFFF.
    n = cyc;
    lsb_req(1'b0, 32'h100, 32'h0, 3'd7);
    push(1'b1, 1'b0, 32'h44332211, n + 5);
    drain(20);
    lsb_en = 1'b0;
    idle(2);
    n = cyc;
    lsb_req(1'b0, 32'hFFFFFFFE, 32'h0, 3'd4);
    push(1'b1, 1'b0, 32'h21105241, n + 5);
    drain(20);
    lsb_en = 1'b0;
    idle(2);

    // SB to IO with the buffer full for three cycles.
    n = cyc; l0 = wlog.size(); w0 = wr_cycles;
    lsb_req(1'b1, 32'h00030000, 32'h0000005A, 3'd1);
    io_buffer_full = 1'b1;
    push(1'b1, 1'b1, 32'h0, n + 5);
    step(); step(); step();
    chk("io_no_wr_in_stall", 32'(wr_cycles - w0), 32'd0);
    io_buffer_full = 1'b0;
    drain(20);
    lsb_en = 1'b0;
    idle(2);
    chk("io_wr_cycles", 32'(wr_cycles - w0), 32'd1);
    chk_wr("io_b0", l0, 32'h00030000, 8'h5A);

    // Just below IO_BASE the full flag is ignored.
    n = cyc; l0 = wlog.size();
    lsb_req(1'b1, 32'h0002FFFF, 32'h00000077, 3'd1);
    io_buffer_full = 1'b1;
    push(1'b1, 1'b1, 32'h0, n + 2);
    drain(20);
    io_buffer_full = 1'b0; lsb_en = 1'b0;
    idle(2);
    chk_wr("ram_edge_b0", l0, 32'h0002FFFF, 8'h77);

    // rdy low two cycles mid-LW; en held through DONE must not re-trigger.
    n = cyc;
    lsb_req(1'b0, 32'h100, 32'h0, 3'd4);
    push(1'b1, 1'b0, 32'h44332211, n + 7);
    step(); step();
    rdy = 1'b0;
    step(); step();
    rdy = 1'b1;
    drain(20);
    step();
    lsb_en = 1'b0;
    idle(3);

    // rdy low mid-SH gates mem_wr and delays the store by one cycle.
    n = cyc; l0 = wlog.size(); w0 = wr_cycles;
    lsb_req(1'b1, 32'h210, 32'h1234BEEF, 3'd2);
    push(1'b1, 1'b1, 32'h0, n + 4);
    step();
    rdy = 1'b0;
    #1;
    chk("mem_wr_gated_by_rdy", {31'd0, mem_wr}, 32'd0);
    step();
    rdy = 1'b1;
    drain(20);
    lsb_en = 1'b0;
    idle(2);
    chk("rdy_sh_wr_cycles", 32'(wr_cycles - w0), 32'd2);
    chk_wr("rdy_sh_b0", l0, 32'h210, 8'hEF);
    chk_wr("rdy_sh_b1", l0 + 1, 32'h211, 8'hBE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
